// File: rtl/model_transformer_vector_transmitter.sv
// Element-serial vector transmitter: buffers a vector written element-by-element,
// then replays it one element per consumer request after START.
module model_transformer_vector_transmitter #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4,
   parameter int L            = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic [DATA_SIZE-1:0] SIZE_IN,
   input  logic                 WR_ENABLE,
   input  logic [DATA_SIZE-1:0] WR_DATA,
   input  logic                 DATA_OUT_REQUEST,
   output logic                 DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] DATA_OUT,
   output logic                 DATA_OUT_LAST
);

   localparam int CW = $clog2(L) + 1;
   localparam int AW = CW - 1;

   // CONTROL_SIZE carries no logic here; it only has to be a legal width.
   if (CONTROL_SIZE < 1 || L < 2) begin : g_param_check
      $error("model_transformer_vector_transmitter: illegal CONTROL_SIZE or L");
   end

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_idx_q, rd_idx_d;
   logic [CW-1:0]         size_q, size_d;
   logic                  ready_q, ready_d;
   logic                  en_q, en_d;
   logic                  last_q, last_d;
   logic [DATA_SIZE-1:0]  data_q, data_d;
   logic [DATA_SIZE-1:0]  mem_q [L];
   logic                  mem_we;
   logic [CW-1:0]         size_clamped;

   // Clamp is decided on the full SIZE_IN width so huge values saturate to L.
   assign size_clamped = (SIZE_IN > DATA_SIZE'(L)) ? CW'(L) : SIZE_IN[CW-1:0];
   assign mem_we       = (state_q == IDLE) && WR_ENABLE;

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= WR_DATA;
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_idx_d = rd_idx_q;
      size_d   = size_q;
      ready_d  = 1'b0;
      en_d     = 1'b0;
      last_d   = 1'b0;
      data_d   = data_q;
      unique case (state_q)
         IDLE: begin
            if (WR_ENABLE) begin
               wr_ptr_d = (wr_ptr_q == CW'(L - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (START) begin
               size_d   = size_clamped;
               rd_idx_d = '0;
               wr_ptr_d = '0;
               if (size_clamped == '0) ready_d = 1'b1;
               else                    state_d = STREAM;
            end
         end
         STREAM: begin
            if (DATA_OUT_REQUEST) begin
               data_d   = mem_q[rd_idx_q[AW-1:0]];
               en_d     = 1'b1;
               rd_idx_d = rd_idx_q + 1'b1;
               if (rd_idx_q == size_q - 1'b1) begin
                  last_d  = 1'b1;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_idx_q <= '0;
         size_q   <= '0;
         ready_q  <= 1'b0;
         en_q     <= 1'b0;
         last_q   <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_idx_q <= rd_idx_d;
         size_q   <= size_d;
         ready_q  <= ready_d;
         en_q     <= en_d;
         last_q   <= last_d;
         data_q   <= data_d;
      end
   end

   assign READY           = ready_q;
   assign DATA_OUT_ENABLE = en_q;
   assign DATA_OUT_LAST   = last_q;
   assign DATA_OUT        = data_q;

endmodule

// File: tb/tb_model_transformer_vector_transmitter.sv
// Directed plus randomized bench for the vector transmitter, checked against a
// transaction-level model (buffer array + queue of elements still to send).
module tb_model_transformer_vector_transmitter;

   localparam int L = 64;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        READY;
   logic [63:0] SIZE_IN;
   logic        WR_ENABLE;
   logic [63:0] WR_DATA;
   logic        DATA_OUT_REQUEST;
   logic        DATA_OUT_ENABLE;
   logic [63:0] DATA_OUT;
   logic        DATA_OUT_LAST;

   model_transformer_vector_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(4), .L(L)) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_IN(SIZE_IN),
      .WR_ENABLE(WR_ENABLE), .WR_DATA(WR_DATA), .DATA_OUT_REQUEST(DATA_OUT_REQUEST),
      .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT), .DATA_OUT_LAST(DATA_OUT_LAST)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [63:0] mbuf [L];
   int          mwr = 0;
   bit          streaming = 0;
   logic [63:0] txq [$];
   logic [63:0] e_data = '0;
   bit          e_en, e_last, e_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("DATA_OUT_ENABLE", 64'(DATA_OUT_ENABLE), 64'(e_en));
      chk("DATA_OUT_LAST",   64'(DATA_OUT_LAST),   64'(e_last));
      chk("READY",           64'(READY),           64'(e_rdy));
      chk("DATA_OUT",        DATA_OUT,             e_data);
   endtask

   // One clock: apply inputs, advance the model, check registered outputs.
   task automatic cyc(input bit st, input logic [63:0] sz, input bit wr,
                      input logic [63:0] wd, input bit req);
      int n;
      @(negedge CLK);
      START = st; SIZE_IN = sz; WR_ENABLE = wr; WR_DATA = wd; DATA_OUT_REQUEST = req;
      e_en = 0; e_last = 0; e_rdy = 0;
      if (!streaming) begin
         if (wr) begin
            mbuf[mwr] = wd;
            mwr = (mwr + 1) % L;
         end
         if (st) begin
            n = (sz > 64'(L)) ? L : int'(sz);
            mwr = 0;
            if (n == 0) e_rdy = 1;
            else begin
               txq.delete();
               for (int i = 0; i < n; i++) txq.push_back(mbuf[i]);
               streaming = 1;
            end
         end
      end else if (req) begin
         e_data = txq.pop_front();
         e_en   = 1;
         if (txq.size() == 0) begin
            e_last = 1; e_rdy = 1; streaming = 0;
         end
      end
      @(posedge CLK);
      #1;
      check_outputs();
   endtask

   task automatic idle_inputs();
      START = 0; SIZE_IN = '0; WR_ENABLE = 0; WR_DATA = '0; DATA_OUT_REQUEST = 0;
   endtask

   initial begin
      RST = 0;
      idle_inputs();
      e_en = 0; e_last = 0; e_rdy = 0;
      #12;
      check_outputs();                                  // reset state
      @(negedge CLK); RST = 1;

      // 1: load 4, stream with a request every cycle (5th request lands in IDLE)
      cyc(0, 0, 1, 64'h11, 0); cyc(0, 0, 1, 64'h22, 0);
      cyc(0, 0, 1, 64'h33, 0); cyc(0, 0, 1, 64'h44, 0);
      cyc(1, 4, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);

      // 2: same vector, requests every third cycle
      cyc(1, 4, 0, 0, 0);
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, (i % 3) == 0);

      // 3: zero length
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);

      // 4: 64 random elements, oversize SIZE_IN clamps to L; START with last write
      for (int i = 0; i < L - 1; i++) cyc(0, 0, 1, {$urandom, $urandom}, 0);
      cyc(1, 100, 1, {$urandom, $urandom}, 0);
      for (int i = 0; i < L + 3; i++) cyc(0, 0, 0, 0, 1);

      // 5: START and writes during STREAM must be ignored
      cyc(1, 4, 0, 0, 0);
      cyc(1, 2, 1, 64'hFF, 1); cyc(1, 9, 1, 64'hFF, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 64'hFF, 1);
      cyc(1, 64'h1_0000_0004, 0, 0, 0);                 // full-width compare -> L elements
      for (int i = 0; i < L + 2; i++) cyc(0, 0, 0, 0, 1);

      // 6: reset after 2 of 4 elements
      cyc(1, 4, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
      @(negedge CLK);
      idle_inputs();
      DATA_OUT_REQUEST = 1;
      RST = 0;
      #1;
      streaming = 0; mwr = 0; e_data = '0; e_en = 0; e_last = 0; e_rdy = 0;
      check_outputs();
      @(negedge CLK); RST = 1;
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [63:0] sz;
         int unsigned r;
         r  = $urandom_range(0, 9);
         sz = (r == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
         cyc($urandom_range(0, 15) == 0, sz, $urandom_range(0, 2) == 0,
             {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
